// File: rtl/sp_window_reader.sv
// ---------------------------------------------------------------------------
// sp_window_reader
//   Read-side sequencer for a PE scratchpad pair. It walks sliding windows
//   over the ifmap scratchpad, reads the matching filter taps, and streams
//   registered (ifmap, filter) pairs to the MAC stage over valid/ready.
//   The scratchpads read combinationally: rdata reflects raddr in the same
//   cycle.
//
// Ports
//   clk, rst        clock / synchronous active-high reset
//   start           one-cycle job request, honoured only while idle
//   base_addr       ifmap address of the first window element
//   filt_len        K, elements per window (1..NUM_REG)
//   stride          window advance (1..NUM_REG)
//   num_windows     windows per job (>=1)
//   ifmap_raddr     ifmap scratchpad read address / ifmap_rdata its data
//   filt_raddr      filter scratchpad read address / filt_rdata its data
//   out_valid       output beat valid / out_ready MAC accepts the beat
//   out_ifmap       ifmap operand / out_filt filter operand
//   out_last_elem   beat is the last element of its window
//   out_last        beat is the final beat of the job
//   busy            job in progress
//   done            one-cycle pulse when the final beat has been accepted
//   cfg_err         one-cycle pulse when a start was rejected
// ---------------------------------------------------------------------------
module sp_window_reader #(
  parameter int NUM_REG    = 12,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] filt_len,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [WIN_WIDTH-1:0]  num_windows,
  output logic [ADDR_WIDTH-1:0] ifmap_raddr,
  input  logic [DATA_WIDTH-1:0] ifmap_rdata,
  output logic [ADDR_WIDTH-1:0] filt_raddr,
  input  logic [DATA_WIDTH-1:0] filt_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_ifmap,
  output logic [DATA_WIDTH-1:0] out_filt,
  output logic                  out_last_elem,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [ADDR_WIDTH:0] NREG = (ADDR_WIDTH+1)'(NUM_REG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   k_reg, win_base_reg, len_reg, stride_reg;
  logic [WIN_WIDTH-1:0]    w_reg, nwin_reg;
  logic [DATA_WIDTH-1:0]   ifmap_data_reg, filt_data_reg;
  logic                    valid_reg, last_elem_reg, last_reg;
  logic                    done_reg, cfg_err_reg;

  logic                    cfg_ok, elem_last, job_last, load;
  logic [ADDR_WIDTH-1:0]   cur_addr, next_base;

  // Both operands are already reduced below NUM_REG and the second is at
  // most NUM_REG, so one conditional subtract completes the modulo.
  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NREG) s = s - NREG;
    return s[ADDR_WIDTH-1:0];
  endfunction

  assign cfg_ok = (filt_len != '0) && ({1'b0, filt_len} <= NREG) &&
                  (stride != '0)   && ({1'b0, stride} <= NREG)   &&
                  (num_windows != '0) && ({1'b0, base_addr} < NREG);

  assign elem_last = (k_reg == len_reg - ADDR_WIDTH'(1));
  assign job_last  = (w_reg == nwin_reg - WIN_WIDTH'(1));
  // The output register can take a new beat when it is empty or draining.
  assign load      = (state_reg == S_RUN) && (!valid_reg || out_ready);
  assign cur_addr  = wrap_add(win_base_reg, k_reg);
  assign next_base = wrap_add(win_base_reg, stride_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    ifmap_raddr = '0;
    filt_raddr  = '0;
    case (state_reg)
      S_IDLE: begin
        if (start && cfg_ok) state_next = S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        ifmap_raddr = cur_addr;
        filt_raddr  = k_reg;
        if (load && elem_last && job_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg          <= '0;
      w_reg          <= '0;
      win_base_reg   <= '0;
      len_reg        <= '0;
      stride_reg     <= '0;
      nwin_reg       <= '0;
      ifmap_data_reg <= '0;
      filt_data_reg  <= '0;
      valid_reg      <= 1'b0;
      last_elem_reg  <= 1'b0;
      last_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              win_base_reg <= base_addr;
              len_reg      <= filt_len;
              stride_reg   <= stride;
              nwin_reg     <= num_windows;
              k_reg        <= '0;
              w_reg        <= '0;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (load) begin
            ifmap_data_reg <= ifmap_rdata;
            filt_data_reg  <= filt_rdata;
            valid_reg      <= 1'b1;
            last_elem_reg  <= elem_last;
            last_reg       <= elem_last && job_last;
            if (elem_last) begin
              k_reg        <= '0;
              w_reg        <= w_reg + WIN_WIDTH'(1);
              win_base_reg <= next_base;
            end else begin
              k_reg <= k_reg + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            valid_reg     <= 1'b0;
            last_elem_reg <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = valid_reg;
  assign out_ifmap     = ifmap_data_reg;
  assign out_filt      = filt_data_reg;
  assign out_last_elem = last_elem_reg;
  assign out_last      = last_reg;
  assign done          = done_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_sp_window_reader.sv
// ---------------------------------------------------------------------------
// tb_sp_window_reader
//   Drives window-read jobs into sp_window_reader against combinational
//   scratchpad models and checks every accepted beat against a queue of
//   expected beats computed from the window arithmetic. A negedge monitor
//   owns all counters; the stimulus process posts its own checks to it.
// ---------------------------------------------------------------------------
module tb_sp_window_reader;
  localparam int NUM_REG = 12;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0, filt_len = '0, stride = '0;
  logic [WW-1:0] num_windows = '0;
  logic [AW-1:0] ifmap_raddr, filt_raddr;
  logic [DW-1:0] ifmap_rdata, filt_rdata, out_ifmap, out_filt;
  logic          out_valid, out_last_elem, out_last, busy, done, cfg_err;
  logic          out_ready = 1'b1;

  logic [DW-1:0] mem_if [16];
  logic [DW-1:0] mem_f  [16];
  assign ifmap_rdata = mem_if[ifmap_raddr];
  assign filt_rdata  = mem_f[filt_raddr];

  sp_window_reader #(.NUM_REG(NUM_REG), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIN_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .filt_len(filt_len),
    .stride(stride), .num_windows(num_windows), .ifmap_raddr(ifmap_raddr),
    .ifmap_rdata(ifmap_rdata), .filt_raddr(filt_raddr), .filt_rdata(filt_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ifmap(out_ifmap), .out_filt(out_filt),
    .out_last_elem(out_last_elem), .out_last(out_last), .busy(busy), .done(done),
    .cfg_err(cfg_err));

  always #5 clk = ~clk;

  typedef struct {int ifm; int flt; int le; int last;} beat_t;
  typedef struct {string name; int act; int exp;} creq_t;

  beat_t q[$];          // expected beats, appended by stimulus only
  creq_t creq[$];       // checks posted by stimulus, scored by monitor
  int    rd_idx = 0, cr_idx = 0;
  int    n_cmp = 0, n_fail = 0;
  int    job_acc = 0, last_job_beats = 0, done_exp = 0;
  int    ready_mode = 0, stall_cnt = 0;
  int    hold_pend = 0, h_ifm = 0, h_flt = 0, h_ra = 0, h_fa = 0;

  task automatic cmp(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic req(input string nm, input int a, input int e);
    creq_t r;
    r.name = nm; r.act = a; r.exp = e;
    creq.push_back(r);
  endtask

  // Monitor: scores posted checks, accepted beats, stall stability, done timing.
  always @(negedge clk) begin
    while (cr_idx < creq.size()) begin
      cmp(creq[cr_idx].name, creq[cr_idx].act, creq[cr_idx].exp);
      cr_idx++;
    end
    if (rst) begin
      rd_idx = q.size(); done_exp = 0; job_acc = 0; hold_pend = 0;
    end else begin
      if (hold_pend != 0) begin
        cmp("hold_valid", int'(out_valid), 1);
        cmp("hold_ifmap", int'(out_ifmap), h_ifm);
        cmp("hold_filt", int'(out_filt), h_flt);
        cmp("hold_ifmap_raddr", int'(ifmap_raddr), h_ra);
        cmp("hold_filt_raddr", int'(filt_raddr), h_fa);
      end
      cmp("done_timing", int'(done), done_exp);
      if (done) begin last_job_beats = job_acc; job_acc = 0; end
      done_exp = 0;
      if (out_valid && out_ready) begin
        if (rd_idx >= q.size()) cmp("extra_beat", 1, 0);
        else begin
          cmp("beat_ifmap", int'(out_ifmap), q[rd_idx].ifm);
          cmp("beat_filt", int'(out_filt), q[rd_idx].flt);
          cmp("beat_last_elem", int'(out_last_elem), q[rd_idx].le);
          cmp("beat_last", int'(out_last), q[rd_idx].last);
          if (q[rd_idx].last != 0) done_exp = 1;
          rd_idx++;
        end
        job_acc++;
      end
      hold_pend = (out_valid && !out_ready) ? 1 : 0;
      h_ifm = int'(out_ifmap); h_flt = int'(out_filt);
      h_ra = int'(ifmap_raddr); h_fa = int'(filt_raddr);
    end
  end

  // Ready generator: always-ready, random, or a 3-cycle stall on beat 2.
  always @(posedge clk) begin
    #1;
    if (job_acc == 0) stall_cnt = 0;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (job_acc == 1 && stall_cnt < 3) begin out_ready = 1'b0; stall_cnt++; end
        else out_ready = 1'b1;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Reference: window w element k reads ifmap[(base + w*stride + k) % N], filt[k].
  task automatic push_job(input int base, input int k, input int st, input int nw);
    beat_t b;
    for (int w = 0; w < nw; w++) begin
      for (int kk = 0; kk < k; kk++) begin
        b.ifm  = int'(mem_if[(base + w * st + kk) % NUM_REG]);
        b.flt  = int'(mem_f[kk]);
        b.le   = (kk == k - 1) ? 1 : 0;
        b.last = (kk == k - 1 && w == nw - 1) ? 1 : 0;
        q.push_back(b);
      end
    end
  endtask

  task automatic issue_start(input int base, input int k, input int st, input int nw);
    @(posedge clk); #1;
    base_addr = AW'(base); filt_len = AW'(k); stride = AW'(st); num_windows = WW'(nw);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic go_job(input int base, input int k, input int st, input int nw, input int poke);
    int got;
    issue_start(base, k, st, nw);
    req("lat_valid_t1", int'(out_valid), 0);
    req("lat_busy", int'(busy), 1);
    req("lat_ifmap_raddr", int'(ifmap_raddr), base);
    req("lat_filt_raddr", int'(filt_raddr), 0);
    @(posedge clk); #1;
    req("lat_valid_t2", int'(out_valid), 1);
    if (poke != 0) begin
      start = 1'b1; filt_len = AW'(1); num_windows = WW'(1); base_addr = AW'(5);
      @(posedge clk); #1;
      start = 1'b0;
      req("busy_start_cfg_err", int'(cfg_err), 0);
    end
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    req("done_seen", got, 1);
    @(posedge clk); #1;
    req("job_beats", last_job_beats, k * nw);
    req("busy_after", int'(busy), 0);
    req("queue_drained", q.size() - rd_idx, 0);
    $display("job base=%0d K=%0d stride=%0d windows=%0d ready_mode=%0d beats=%0d",
             base, k, st, nw, ready_mode, last_job_beats);
  endtask

  task automatic reject(input int base, input int k, input int st, input int nw);
    issue_start(base, k, st, nw);
    req("cfg_err_pulse", int'(cfg_err), 1);
    req("cfg_err_busy", int'(busy), 0);
    @(posedge clk); #1;
    req("cfg_err_clear", int'(cfg_err), 0);
    req("cfg_err_busy2", int'(busy), 0);
    $display("reject base=%0d K=%0d stride=%0d windows=%0d", base, k, st, nw);
  endtask

  initial begin : stim
    int idx0, got;
    int e_ifm1 [6] = '{1, 2, 3, 2, 3, 4};
    int e_flt1 [6] = '{0, 10, 20, 0, 10, 20};
    int e_le1  [6] = '{0, 0, 1, 0, 0, 1};
    int e_lst1 [6] = '{0, 0, 0, 0, 0, 1};
    int e_ifm2 [6] = '{11, 12, 1, 1, 2, 3};

    for (int i = 0; i < 16; i++) begin
      mem_if[i] = DW'(i + 1);
      mem_f[i]  = DW'(10 * i);
    end
    repeat (3) @(posedge clk);
    #1;
    req("rst_valid", int'(out_valid), 0);
    req("rst_busy", int'(busy), 0);
    req("rst_done", int'(done), 0);
    req("rst_cfg_err", int'(cfg_err), 0);
    req("rst_ifmap_raddr", int'(ifmap_raddr), 0);
    rst = 1'b0;

    // Basic job with pinned expectations for the reference itself.
    idx0 = q.size();
    push_job(0, 3, 1, 2);
    for (int i = 0; i < 6; i++) begin
      req("pin1_ifm", q[idx0 + i].ifm, e_ifm1[i]);
      req("pin1_flt", q[idx0 + i].flt, e_flt1[i]);
      req("pin1_le", q[idx0 + i].le, e_le1[i]);
      req("pin1_last", q[idx0 + i].last, e_lst1[i]);
    end
    go_job(0, 3, 1, 2, 0);

    // Same job with a stall on beat 2.
    ready_mode = 2;
    push_job(0, 3, 1, 2);
    go_job(0, 3, 1, 2, 0);
    ready_mode = 0;

    // Wrap-around windows.
    idx0 = q.size();
    push_job(10, 3, 2, 2);
    for (int i = 0; i < 6; i++) req("pin2_ifm", q[idx0 + i].ifm, e_ifm2[i]);
    go_job(10, 3, 2, 2, 0);

    // Illegal configurations.
    reject(0, 0, 1, 2);
    reject(0, 3, 13, 2);
    reject(0, 3, 1, 0);
    reject(12, 3, 1, 2);

    // Start pulse while busy must be ignored.
    push_job(0, 3, 1, 2);
    go_job(0, 3, 1, 2, 1);

    // Reset during beat 4, then a fresh job.
    push_job(0, 3, 1, 2);
    issue_start(0, 3, 1, 2);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (job_acc >= 3) begin got = 1; break; end
    end
    req("reach_beat4", got, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    req("midrst_valid", int'(out_valid), 0);
    req("midrst_ifmap", int'(out_ifmap), 0);
    req("midrst_filt", int'(out_filt), 0);
    req("midrst_last", int'(out_last), 0);
    req("midrst_last_elem", int'(out_last_elem), 0);
    req("midrst_busy", int'(busy), 0);
    req("midrst_done", int'(done), 0);
    req("midrst_ifmap_raddr", int'(ifmap_raddr), 0);
    req("midrst_filt_raddr", int'(filt_raddr), 0);
    rst = 1'b0;
    push_job(0, 3, 1, 2);
    go_job(0, 3, 1, 2, 0);

    // Randomised jobs with random contents and backpressure.
    for (int j = 0; j < 20; j++) begin
      int b, k, s, n;
      for (int i = 0; i < 16; i++) begin
        mem_if[i] = DW'($urandom);
        mem_f[i]  = DW'($urandom);
      end
      ready_mode = int'($urandom_range(0, 1));
      b = int'($urandom_range(0, NUM_REG - 1));
      k = int'($urandom_range(1, NUM_REG));
      s = int'($urandom_range(1, NUM_REG));
      n = int'($urandom_range(1, 6));
      push_job(b, k, s, n);
      go_job(b, k, s, n, 0);
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
